// File: rtl/fc_pkg.sv
// Shared constants, FSM state encoding and the accumulator post-processing function for the FC sequencer.
// Purely combinational helpers; no timing or backpressure of its own.
package fc_pkg;

  localparam int FC_NUM_CLASSES = 27;
  localparam int FC_ROW_WORDS   = 48;
  localparam int FC_ACC_W       = 21;
  localparam int FC_SHIFT       = 4;
  localparam int FC_MEM_LAT     = 1;
  localparam int FC_CLS_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } fc_state_e;

  // Arithmetic shift then clamp to the int8 range.
  function automatic logic signed [7:0] fc_sat8(input logic signed [FC_ACC_W-1:0] acc);
    logic signed [FC_ACC_W-1:0] v;
    logic signed [FC_ACC_W-1:0] hi;
    logic signed [FC_ACC_W-1:0] lo;
    hi = FC_ACC_W'(127);
    lo = FC_ACC_W'(-128);
    v  = acc >>> FC_SHIFT;
    if (v > hi)      fc_sat8 = 8'sd127;
    else if (v < lo) fc_sat8 = -8'sd128;
    else             fc_sat8 = v[7:0];
  endfunction

endpackage

// File: rtl/fc_argmax.sv
// Running argmax over saturated row results; result registers load only on the final row.
// One-cycle update per accepted accumulator; never stalls its producer.
module fc_argmax
  import fc_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       acc_valid,
  input  logic [FC_CLS_W-1:0]        row_idx,
  input  logic                       final_row,
  input  logic signed [FC_ACC_W-1:0] acc_data,
  output logic [FC_CLS_W-1:0]        o_class,
  output logic [7:0]                 o_max
);

  logic signed [7:0]   sat;
  logic signed [7:0]   best_max;
  logic [FC_CLS_W-1:0] best_cls;
  logic                take;

  assign sat  = fc_sat8(acc_data);
  // Strict compare: an equal later row never displaces an earlier winner.
  assign take = (row_idx == '0) || (sat > best_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_cls <= '0;
      best_max <= '0;
    end else if (clear) begin
      best_cls <= '0;
      best_max <= '0;
    end else if (acc_valid && take) begin
      best_cls <= row_idx;
      best_max <= sat;
    end
  end

  // Published result only changes on completion, so an aborted run leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_class <= '0;
      o_max   <= '0;
    end else if (acc_valid && final_row) begin
      o_class <= take ? row_idx : best_cls;
      o_max   <= take ? sat : best_max;
    end
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// FC classifier sequencer: walks all class rows over shared fm/weight memories, tags MAC beats, reports argmax.
// Beats follow grants by MEM_LAT cycles; a low grant holds request and addresses stable.
module fc_seq_ctrl
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int ROW_WORDS   = FC_ROW_WORDS,
  parameter int MEM_LAT     = FC_MEM_LAT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [8:0]                 i_fm_base,
  input  logic [12:0]                i_w_base,
  output logic                       o_busy,
  output logic                       o_mem_req,
  input  logic                       i_mem_gnt,
  output logic [15:0]                o_fm_addr,
  output logic [15:0]                o_w_addr,
  output logic                       o_mac_valid,
  output logic                       o_mac_first,
  output logic                       o_mac_last,
  input  logic                       i_acc_valid,
  input  logic signed [FC_ACC_W-1:0] i_acc_data,
  output logic                       o_done,
  output logic [FC_CLS_W-1:0]        o_class,
  output logic [7:0]                 o_max
);

  localparam int                  K_W      = $clog2(ROW_WORDS);
  localparam logic [K_W-1:0]      K_LAST   = K_W'(ROW_WORDS - 1);
  localparam logic [FC_CLS_W-1:0] C_LAST   = FC_CLS_W'(NUM_CLASSES - 1);
  localparam logic [15:0]         ROW_STEP = 16'(ROW_WORDS);

  fc_state_e           state, state_nxt;
  logic [K_W-1:0]      k;
  logic [FC_CLS_W-1:0] c;
  logic [FC_CLS_W-1:0] rows;
  logic [15:0]         fm_base;
  logic [15:0]         w_row;
  logic                start_ok;
  logic                fire;
  logic                row_end;
  logic                acc_take;
  logic                acc_final;
  logic [2:0]          pipe [MEM_LAT];

  assign start_ok  = (state == ST_IDLE) && i_start && !i_abort;
  assign o_mem_req = (state == ST_ISSUE);
  assign fire      = o_mem_req && i_mem_gnt;
  assign row_end   = (k == K_LAST);
  assign acc_take  = i_acc_valid && !i_abort && ((state == ST_ISSUE) || (state == ST_DRAIN));
  assign acc_final = acc_take && (rows == C_LAST);
  assign o_fm_addr = fm_base + 16'(k);
  assign o_w_addr  = w_row + 16'(k);
  assign o_busy    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign o_done    = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (acc_final)                             state_nxt = ST_DONE;
        else if (fire && row_end && (c == C_LAST)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (acc_final) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (i_abort) state_nxt = ST_IDLE;
  end

  // Weight row base steps by ROW_WORDS per row instead of computing c*ROW_WORDS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      c       <= '0;
      rows    <= '0;
      fm_base <= '0;
      w_row   <= '0;
    end else if (start_ok) begin
      k       <= '0;
      c       <= '0;
      rows    <= '0;
      fm_base <= 16'(i_fm_base);
      w_row   <= 16'(i_w_base);
    end else begin
      if (fire) begin
        if (row_end) begin
          k     <= '0;
          c     <= c + 1'b1;
          w_row <= w_row + ROW_STEP;
        end else begin
          k <= k + 1'b1;
        end
      end
      if (acc_take) rows <= rows + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || i_abort) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {fire, fire && (k == '0), fire && row_end};
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {o_mac_valid, o_mac_first, o_mac_last} = pipe[MEM_LAT-1];

  fc_argmax u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .acc_valid (acc_take),
    .row_idx   (rows),
    .final_row (rows == C_LAST),
    .acc_data  (i_acc_data),
    .o_class   (o_class),
    .o_max     (o_max)
  );

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl: scoreboarded addresses and MAC tags, emulated datapath returning row sums.
module tb_fc_seq_ctrl;
  import fc_pkg::*;

  localparam int NC = FC_NUM_CLASSES;
  localparam int RW = FC_ROW_WORDS;
  localparam int AW = FC_ACC_W;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_start = 1'b0;
  logic                 i_abort = 1'b0;
  logic [8:0]           i_fm_base = '0;
  logic [12:0]          i_w_base = '0;
  logic                 o_busy, o_mem_req, i_mem_gnt = 1'b0;
  logic [15:0]          o_fm_addr, o_w_addr;
  logic                 o_mac_valid, o_mac_first, o_mac_last;
  logic                 i_acc_valid = 1'b0;
  logic signed [AW-1:0] i_acc_data = '0;
  logic                 o_done;
  logic [4:0]           o_class;
  logic [7:0]           o_max;

  fc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_fm_base(i_fm_base), .i_w_base(i_w_base), .o_busy(o_busy),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_fm_addr(o_fm_addr),
    .o_w_addr(o_w_addr), .o_mac_valid(o_mac_valid), .o_mac_first(o_mac_first),
    .o_mac_last(o_mac_last), .i_acc_valid(i_acc_valid), .i_acc_data(i_acc_data),
    .o_done(o_done), .o_class(o_class), .o_max(o_max)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] fm;
    logic [15:0] w;
  } addr_t;

  int          errors = 0;
  int          checks = 0;
  int          acc_tbl [NC];
  addr_t       addr_q [$];
  logic [1:0]  flag_q [$];
  int          done_cnt, last_req_cyc;
  logic [4:0]  got_cls, exp_cls;
  logic [7:0]  got_max, exp_max;

  task automatic model();
    int best, v, bi;
    best = 0;
    bi = 0;
    for (int r = 0; r < NC; r++) begin
      v = acc_tbl[r] >>> 4;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      if (r == 0 || v > best) begin
        best = v;
        bi = r;
      end
    end
    exp_cls = 5'(bi);
    exp_max = 8'(best);
  endtask

  // Drives one inference and acts as memory arbiter plus FC datapath.
  task automatic run_inference(input logic [8:0] fm_b, input logic [12:0] w_b,
                               input bit toggle, input int abort_word, input int budget);
    addr_t      a;
    logic [1:0] fl;
    int         cyc, words, acc_row, acc_due, done_exp, stop;
    bit         aborted, fired_prev, fired, gnt, exp_busy;
    addr_q.delete();
    flag_q.delete();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < RW; k++) begin
        a.fm = 16'(fm_b + k);
        a.w  = 16'(w_b + c * RW + k);
        addr_q.push_back(a);
      end
    done_cnt = 0; last_req_cyc = -1; words = 0; acc_row = 0; acc_due = -1;
    done_exp = -1; aborted = 0; fired_prev = 0; stop = budget;
    @(negedge clk);
    i_fm_base = fm_b; i_w_base = w_b; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_fm_base = '0; i_w_base = '0;
    cyc = 1;
    while (cyc < stop) begin
      gnt = toggle ? (cyc % 2 == 1) : 1'b1;
      i_mem_gnt = gnt;
      exp_busy = !aborted && !(done_exp >= 0 && cyc >= done_exp);
      checks++;
      if (o_busy !== exp_busy) begin
        errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, exp_busy);
      end
      checks++;
      if (o_mem_req !== (addr_q.size() > 0)) begin
        errors++; $display("FAIL mem_req cyc=%0d got=%b exp=%b", cyc, o_mem_req, addr_q.size() > 0);
      end
      fired = 1'b0;
      if (addr_q.size() > 0) begin
        checks++;
        if (o_fm_addr !== addr_q[0].fm || o_w_addr !== addr_q[0].w) begin
          errors++;
          $display("FAIL addr cyc=%0d got fm=%0d w=%0d exp fm=%0d w=%0d",
                   cyc, o_fm_addr, o_w_addr, addr_q[0].fm, addr_q[0].w);
        end
        if (gnt) begin
          a = addr_q.pop_front();
          fired = 1'b1;
          last_req_cyc = cyc;
          flag_q.push_back({words % RW == 0, words % RW == RW - 1});
          words++;
        end
      end
      checks++;
      if (o_mac_valid !== fired_prev) begin
        errors++; $display("FAIL mac_valid cyc=%0d got=%b exp=%b", cyc, o_mac_valid, fired_prev);
      end
      if (fired_prev && flag_q.size() > 0) begin
        fl = flag_q.pop_front();
        checks++;
        if ({o_mac_first, o_mac_last} !== fl) begin
          errors++; $display("FAIL mac_tags cyc=%0d got=%b exp=%b", cyc, {o_mac_first, o_mac_last}, fl);
        end
        if (fl[0]) acc_due = cyc + 2;
      end
      i_acc_valid = 1'b0;
      if (cyc == acc_due && !aborted) begin
        i_acc_valid = 1'b1;
        i_acc_data = AW'(acc_tbl[acc_row]);
        acc_row++;
        if (acc_row == NC) begin
          done_exp = cyc + 1;
          stop = cyc + 4;
        end
      end
      checks++;
      if (o_done !== (cyc == done_exp)) begin
        errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, o_done, cyc == done_exp);
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        got_cls = o_class;
        got_max = o_max;
      end
      // A start while busy must be ignored, bases included.
      i_start = (cyc == 100);
      if (i_start) begin
        i_fm_base = 9'h1aa;
        i_w_base = 13'h1555;
      end
      if (abort_word >= 0 && !aborted && words >= abort_word) begin
        i_abort = 1'b1;
        aborted = 1;
        fired = 1'b0;
        acc_due = -1;
        addr_q.delete();
        flag_q.delete();
        stop = cyc + 20;
      end
      fired_prev = fired;
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0; i_fm_base = '0; i_w_base = '0;
      cyc++;
    end
    i_acc_valid = 1'b0;
    i_mem_gnt = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    checks++;
    if ({o_busy, o_mem_req, o_fm_addr, o_w_addr, o_mac_valid, o_mac_first, o_mac_last,
         o_done, o_class, o_max} !== '0) begin
      errors++; $display("FAIL reset_outputs got busy=%b req=%b fm=%h w=%h class=%0d max=%h exp all zero",
                         o_busy, o_mem_req, o_fm_addr, o_w_addr, o_class, o_max);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int r = 0; r < NC; r++) acc_tbl[r] = 16 * r;
    model();
    run_inference(9'd0, 13'd0, 1'b0, -1, 1500);
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL ramp_done_count got=%0d exp=1", done_cnt); end
    checks++;
    if (got_cls !== exp_cls || got_max !== exp_max) begin
      errors++; $display("FAIL ramp_result got class=%0d max=%0d exp class=%0d max=%0d", got_cls, got_max, exp_cls, exp_max);
    end
    checks++;
    if (last_req_cyc !== NC * RW) begin
      errors++; $display("FAIL ramp_latency got=%0d exp=%0d", last_req_cyc, NC * RW);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (o_class !== exp_cls || o_max !== exp_max) begin
      errors++; $display("FAIL ramp_hold got class=%0d max=%0d exp class=%0d max=%0d", o_class, o_max, exp_cls, exp_max);
    end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < NC; r++) acc_tbl[r] = (r == 3) ? 2047 : -5000;
    model();
    run_inference(9'd17, 13'd300, 1'b0, -1, 1500);
    checks++;
    if (done_cnt !== 1 || got_cls !== exp_cls || got_max !== exp_max) begin
      errors++; $display("FAIL saturate got done=%0d class=%0d max=%0d exp done=1 class=%0d max=%0d",
                         done_cnt, got_cls, got_max, exp_cls, exp_max);
    end
  endtask

  task automatic test_tie();
    for (int r = 0; r < NC; r++) acc_tbl[r] = 320;
    model();
    run_inference(9'd3, 13'd7, 1'b0, -1, 1500);
    checks++;
    if (done_cnt !== 1 || got_cls !== exp_cls || got_max !== exp_max) begin
      errors++; $display("FAIL tie got done=%0d class=%0d max=%0d exp done=1 class=%0d max=%0d",
                         done_cnt, got_cls, got_max, exp_cls, exp_max);
    end
  endtask

  task automatic test_gnt_toggle();
    for (int r = 0; r < NC; r++) acc_tbl[r] = (r == 13) ? 900 : -16 * r;
    model();
    run_inference(9'd5, 13'd100, 1'b1, -1, 3000);
    checks++;
    if (done_cnt !== 1 || got_cls !== exp_cls || got_max !== exp_max) begin
      errors++; $display("FAIL gnt_toggle got done=%0d class=%0d max=%0d exp done=1 class=%0d max=%0d",
                         done_cnt, got_cls, got_max, exp_cls, exp_max);
    end
    checks++;
    if (last_req_cyc !== 2 * NC * RW - 1) begin
      errors++; $display("FAIL gnt_toggle_last_req got=%0d exp=%0d", last_req_cyc, 2 * NC * RW - 1);
    end
  endtask

  task automatic test_abort();
    logic [4:0] prev_cls;
    logic [7:0] prev_max;
    prev_cls = exp_cls;
    prev_max = exp_max;
    for (int r = 0; r < NC; r++) acc_tbl[r] = 100 * r;
    run_inference(9'd0, 13'd0, 1'b0, 10 * RW + 20, 1500);
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++;
    if (o_class !== prev_cls || o_max !== prev_max) begin
      errors++; $display("FAIL abort_result_kept got class=%0d max=%0d exp class=%0d max=%0d", o_class, o_max, prev_cls, prev_max);
    end
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL start_abort_same_cycle got busy=%b req=%b exp 0 0", o_busy, o_mem_req);
    end
    for (int r = 0; r < NC; r++) acc_tbl[r] = (r == 20) ? 1000 : -5000;
    model();
    run_inference(9'd40, 13'd2000, 1'b0, -1, 1500);
    checks++;
    if (done_cnt !== 1 || got_cls !== exp_cls || got_max !== exp_max) begin
      errors++; $display("FAIL abort_restart got done=%0d class=%0d max=%0d exp done=1 class=%0d max=%0d",
                         done_cnt, got_cls, got_max, exp_cls, exp_max);
    end
  endtask

  task automatic test_reset_drain();
    @(negedge clk);
    i_start = 1'b1; i_mem_gnt = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (NC * RW + 3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1 || o_mem_req !== 1'b0) begin
      errors++; $display("FAIL drain_state got busy=%b req=%b exp 1 0", o_busy, o_mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_mem_req, o_fm_addr, o_w_addr, o_mac_valid, o_mac_first, o_mac_last,
         o_done, o_class, o_max} !== '0) begin
      errors++; $display("FAIL reset_mid_drain got busy=%b req=%b fm=%h w=%h class=%0d max=%h exp all zero",
                         o_busy, o_mem_req, o_fm_addr, o_w_addr, o_class, o_max);
    end
    i_mem_gnt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < NC; r++) acc_tbl[r] = (r == 26) ? 1600 : 50 * r;
    model();
    run_inference(9'd511, 13'd8191, 1'b0, -1, 1500);
    checks++;
    if (done_cnt !== 1 || got_cls !== exp_cls || got_max !== exp_max) begin
      errors++; $display("FAIL after_reset_run got done=%0d class=%0d max=%0d exp done=1 class=%0d max=%0d",
                         done_cnt, got_cls, got_max, exp_cls, exp_max);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturate();
    test_tie();
    test_gnt_toggle();
    test_abort();
    test_reset_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
